// File: rtl/clock_divider_multi.sv
// Multi-channel clock-enable divider. Each channel produces a registered 50 %-duty square wave
// and a one-cycle tick on its rising edge. A shadow register holds each new half-period until
// the next half-period boundary, so reprogramming never produces a short or long half-cycle.
module clock_divider_multi #(
  parameter int unsigned Channels    = 4,
  parameter int unsigned Width       = 17,
  parameter int unsigned DefaultHalf = 65536,
  localparam int unsigned SelW       = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [Channels-1:0] en_i,
  input  logic                div_wr_i,
  input  logic [SelW-1:0]     div_sel_i,
  input  logic [Width-1:0]    div_data_i,
  input  logic                sync_clr_i,
  output logic [Channels-1:0] clk_out_o,
  output logic [Channels-1:0] tick_o,
  output logic [Channels-1:0] pending_o
);

  logic [Channels-1:0][Width-1:0] cnt_q, cnt_d;
  logic [Channels-1:0][Width-1:0] half_q, half_d;
  logic [Channels-1:0][Width-1:0] shadow_q, shadow_d;
  logic [Channels-1:0]            clk_q, clk_d;
  logic [Channels-1:0]            tick_q, tick_d;
  logic [Channels-1:0]            pend_q, pend_d;

  logic [Channels-1:0][Width-1:0] eff;
  logic [Channels-1:0]            term;
  logic [Channels-1:0]            commit;

  // Per-channel next state: clear > freeze > terminal count > increment, then shadow handling.
  always_comb begin
    cnt_d    = cnt_q;
    half_d   = half_q;
    shadow_d = shadow_q;
    clk_d    = clk_q;
    tick_d   = '0;
    pend_d   = pend_q;
    eff      = '0;
    term     = '0;
    commit   = '0;
    for (int i = 0; i < Channels; i++) begin
      // A half-period of 0 behaves as 1, so eff-1 never underflows.
      eff[i]  = (half_q[i] == '0) ? Width'(1) : half_q[i];
      term[i] = (cnt_q[i] == eff[i] - Width'(1));

      if (sync_clr_i) begin
        cnt_d[i]  = '0;
        clk_d[i]  = 1'b0;
        commit[i] = 1'b1;
      end else if (!en_i[i]) begin
        // Frozen: count and level hold, but a pending value may take effect right away.
        commit[i] = 1'b1;
      end else if (term[i]) begin
        cnt_d[i]  = '0;
        clk_d[i]  = ~clk_q[i];
        tick_d[i] = ~clk_q[i];
        commit[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + Width'(1);
      end

      // Commit uses the old shadow; a write on the same edge stays pending for the next boundary.
      if (commit[i] && pend_q[i]) begin
        half_d[i] = shadow_q[i];
        pend_d[i] = 1'b0;
      end

      if (div_wr_i && (div_sel_i == SelW'(i))) begin
        shadow_d[i] = div_data_i;
        pend_d[i]   = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      half_q   <= {Channels{Width'(DefaultHalf)}};
      shadow_q <= {Channels{Width'(DefaultHalf)}};
      clk_q    <= '0;
      tick_q   <= '0;
      pend_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      shadow_q <= shadow_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
    end
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi with a reduced counter width so the default period is short.
module tb_clock_divider_multi;

  localparam int unsigned Ch  = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned Def = 128;
  localparam int unsigned Mod = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [Ch-1:0] en;
  logic          div_wr;
  logic [1:0]    div_sel;
  logic [W-1:0]  div_data;
  logic          sync_clr;
  logic [Ch-1:0] clk_out, tick, pending;

  // Three-channel instance: a select value equal to the channel count is representable.
  logic [2:0]    en3;
  logic          wr3;
  logic [1:0]    sel3;
  logic [W-1:0]  data3;
  logic          clr3;
  logic [2:0]    clk_out3, tick3, pending3;

  int checks = 0;
  int errors = 0;

  // Reference model state: elapsed cycles in the current half-period, level, tick, halves.
  int m_age[Ch];
  int m_half[Ch];
  int m_sh[Ch];
  bit m_lvl[Ch];
  bit m_tk[Ch];
  bit m_pend[Ch];

  clock_divider_multi #(.Channels(Ch), .Width(W), .DefaultHalf(Def)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .div_wr_i(div_wr), .div_sel_i(div_sel),
    .div_data_i(div_data), .sync_clr_i(sync_clr), .clk_out_o(clk_out), .tick_o(tick),
    .pending_o(pending)
  );

  clock_divider_multi #(.Channels(3), .Width(W), .DefaultHalf(Def)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en3), .div_wr_i(wr3), .div_sel_i(sel3),
    .div_data_i(data3), .sync_clr_i(clr3), .clk_out_o(clk_out3), .tick_o(tick3),
    .pending_o(pending3)
  );

  always #5 clk = ~clk;

  function automatic logic [3*Ch-1:0] model_vec();
    logic [3*Ch-1:0] v;
    v = '0;
    for (int i = 0; i < Ch; i++) begin
      v[2*Ch+i] = m_lvl[i];
      v[Ch+i]   = m_tk[i];
      v[i]      = m_pend[i];
    end
    return v;
  endfunction

  task automatic model_step();
    for (int i = 0; i < Ch; i++) begin
      bit commit;
      int len;
      commit = 1'b0;
      if (!rst_n) begin
        m_age[i] = 0; m_lvl[i] = 0; m_tk[i] = 0;
        m_half[i] = Def; m_sh[i] = Def; m_pend[i] = 0;
      end else begin
        if (sync_clr) begin
          m_age[i] = 0; m_lvl[i] = 0; m_tk[i] = 0; commit = 1'b1;
        end else if (!en[i]) begin
          m_tk[i] = 0; commit = 1'b1;
        end else begin
          len = (m_half[i] == 0) ? 1 : m_half[i];
          if (m_age[i] + 1 == len) begin
            m_age[i] = 0;
            m_lvl[i] = !m_lvl[i];
            m_tk[i]  = m_lvl[i];
            commit   = 1'b1;
          end else begin
            m_age[i] = (m_age[i] + 1) % Mod;
            m_tk[i]  = 0;
          end
        end
        if (commit && m_pend[i]) begin
          m_half[i] = m_sh[i];
          m_pend[i] = 0;
        end
        if (div_wr && int'(div_sel) == i) begin
          m_sh[i]   = int'(div_data);
          m_pend[i] = 1;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = '0;
    repeat (3) cycle();
    checks++;
    if ({clk_out, tick, pending} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got %h want 000", {clk_out, tick, pending});
    end
    en = 4'b0001;
    rst_n = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      cycle();
      checks++;
      if (clk_out[0] !== ((k / 128) % 2 == 1)) begin
        errors++;
        $display("FAIL default_clk edge %0d got %b want %b", k, clk_out[0], (k / 128) % 2 == 1);
      end
      checks++;
      if (tick[0] !== (k % 256 == 128)) begin
        errors++;
        $display("FAIL default_tick edge %0d got %b want %b", k, tick[0], k % 256 == 128);
      end
      checks++;
      if ({clk_out[3:1], tick[3:1]} !== 6'b0) begin
        errors++;
        $display("FAIL default_idle edge %0d got %b want 000000", k, {clk_out[3:1], tick[3:1]});
      end
    end
  endtask

  task automatic test_min_divide();
    logic prev;
    en = '0;
    div_wr = 1'b1; div_sel = 2'd1; div_data = 8'd0;
    cycle();
    div_wr = 1'b0;
    checks++;
    if (pending[1] !== 1'b1) begin
      errors++;
      $display("FAIL min_pend_set got %b want 1", pending[1]);
    end
    cycle();
    checks++;
    if (pending[1] !== 1'b0) begin
      errors++;
      $display("FAIL min_pend_clr got %b want 0", pending[1]);
    end
    en = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      checks++;
      if ({clk_out[1], tick[1]} !== {2{k[0]}}) begin
        errors++;
        $display("FAIL min_half0 edge %0d got %b want %b", k, {clk_out[1], tick[1]}, {2{k[0]}});
      end
    end
    en = '0;
    div_wr = 1'b1; div_sel = 2'd1; div_data = 8'd1;
    cycle();
    div_wr = 1'b0;
    cycle();
    en = 4'b0010;
    prev = clk_out[1];
    for (int k = 1; k <= 8; k++) begin
      cycle();
      checks++;
      if (clk_out[1] === prev || tick[1] !== (clk_out[1] && !prev)) begin
        errors++;
        $display("FAIL min_half1 edge %0d got clk %b tick %b want clk %b tick %b",
                 k, clk_out[1], tick[1], !prev, !prev);
      end
      prev = clk_out[1];
    end
  endtask

  task automatic test_reprogram();
    logic prev;
    bit exp_t;
    en = '0;
    div_wr = 1'b1; div_sel = 2'd2; div_data = 8'd10;
    cycle();
    div_wr = 1'b0;
    cycle();
    sync_clr = 1'b1;
    cycle();
    sync_clr = 1'b0;
    en = 4'b0100;
    prev = clk_out[2];
    for (int k = 1; k <= 32; k++) begin
      if (k == 5) begin
        div_wr = 1'b1; div_sel = 2'd2; div_data = 8'd3;
      end
      cycle();
      div_wr = 1'b0;
      exp_t = (k == 10) || (k > 10 && (k - 10) % 3 == 0);
      checks++;
      if ((clk_out[2] !== prev) !== exp_t) begin
        errors++;
        $display("FAIL reprog_toggle edge %0d got %b want %b", k, clk_out[2] !== prev, exp_t);
      end
      checks++;
      if (pending[2] !== (k >= 5 && k < 10)) begin
        errors++;
        $display("FAIL reprog_pend edge %0d got %b want %b", k, pending[2], k >= 5 && k < 10);
      end
      prev = clk_out[2];
    end
  endtask

  task automatic test_phase_align();
    int halves[Ch] = '{5, 7, 5, 9};
    en = '0;
    for (int c = 0; c < Ch; c++) begin
      div_wr = 1'b1; div_sel = 2'(c); div_data = 8'(halves[c]);
      cycle();
      div_wr = 1'b0;
      cycle();
    end
    for (int c = 0; c < Ch; c++) begin
      en[c] = 1'b1;
      repeat (3 + 2 * c) cycle();
    end
    sync_clr = 1'b1;
    cycle();
    sync_clr = 1'b0;
    checks++;
    if ({clk_out, tick} !== 8'h00) begin
      errors++;
      $display("FAIL align_clear got %h want 00", {clk_out, tick});
    end
    en = 4'hf;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      checks++;
      if (tick[0] !== (k % 10 == 5) || tick[2] !== (k % 10 == 5)) begin
        errors++;
        $display("FAIL align_tick edge %0d got %b%b want %b", k, tick[2], tick[0], k % 10 == 5);
      end
      checks++;
      if (clk_out[1] !== ((k / 7) % 2 == 1) || clk_out[3] !== ((k / 9) % 2 == 1)) begin
        errors++;
        $display("FAIL align_clk13 edge %0d got %b%b want %b%b", k, clk_out[3], clk_out[1],
                 (k / 9) % 2 == 1, (k / 7) % 2 == 1);
      end
      checks++;
      if ({clk_out, tick, pending} !== model_vec()) begin
        errors++;
        $display("FAIL align_model edge %0d got %h want %h", k, {clk_out, tick, pending},
                 model_vec());
      end
    end
  endtask

  task automatic test_freeze();
    en = '0;
    div_wr = 1'b1; div_sel = 2'd3; div_data = 8'd8;
    cycle();
    div_wr = 1'b0;
    cycle();
    sync_clr = 1'b1;
    cycle();
    sync_clr = 1'b0;
    en = 4'b1000;
    repeat (13) cycle();
    checks++;
    if (clk_out[3] !== 1'b1) begin
      errors++;
      $display("FAIL freeze_pre got %b want 1", clk_out[3]);
    end
    en = '0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      checks++;
      if ({clk_out[3], tick[3]} !== 2'b10) begin
        errors++;
        $display("FAIL freeze_hold cycle %0d got %b want 10", k, {clk_out[3], tick[3]});
      end
    end
    en = 4'b1000;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      checks++;
      if (clk_out[3] !== (k < 3)) begin
        errors++;
        $display("FAIL freeze_resume edge %0d got %b want %b", k, clk_out[3], k < 3);
      end
    end
  endtask

  task automatic test_edge_cases();
    en = 4'b0001;
    div_wr = 1'b1; div_sel = 2'd0; div_data = 8'd9;
    cycle();
    div_wr = 1'b0;
    checks++;
    if (pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL edge_pend got %b want 1", pending[0]);
    end
    rst_n = 1'b0;
    cycle();
    checks++;
    if ({clk_out, tick, pending, clk_out3, tick3, pending3} !== 21'h0) begin
      errors++;
      $display("FAIL edge_reset got %h want 0",
               {clk_out, tick, pending, clk_out3, tick3, pending3});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      cycle();
      checks++;
      if ({clk_out[0], tick[0]} !== {k >= 128, k == 128}) begin
        errors++;
        $display("FAIL edge_default edge %0d got %b want %b", k, {clk_out[0], tick[0]},
                 {k >= 128, k == 128});
      end
    end
    en = '0;
    wr3 = 1'b1; sel3 = 2'd3; data3 = 8'd2;
    cycle();
    wr3 = 1'b0;
    checks++;
    if (pending3 !== 3'b000) begin
      errors++;
      $display("FAIL edge_badsel_pend got %b want 000", pending3);
    end
    en3 = 3'b111;
    for (int k = 1; k <= 130; k++) begin
      cycle();
      checks++;
      if (clk_out3 !== ((k >= 128) ? 3'b111 : 3'b000)) begin
        errors++;
        $display("FAIL edge_badsel_clk edge %0d got %b want %b", k, clk_out3,
                 (k >= 128) ? 3'b111 : 3'b000);
      end
    end
    en3 = '0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      rst_n    = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 7) == 0) en = 4'($urandom);
      div_wr   = ($urandom_range(0, 3) == 0);
      div_sel  = 2'($urandom_range(0, 3));
      div_data = 8'($urandom_range(0, 12));
      sync_clr = ($urandom_range(0, 59) == 0);
      cycle();
      checks++;
      if ({clk_out, tick, pending} !== model_vec()) begin
        errors++;
        $display("FAIL random_model cycle %0d got %h want %h", k, {clk_out, tick, pending},
                 model_vec());
      end
    end
    rst_n = 1'b1; div_wr = 1'b0; sync_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = '0; div_wr = 1'b0; div_sel = '0; div_data = '0; sync_clr = 1'b0;
    en3 = '0; wr3 = 1'b0; sel3 = '0; data3 = '0; clr3 = 1'b0;
    test_reset();
    test_min_divide();
    test_reprogram();
    test_phase_align();
    test_freeze();
    test_edge_cases();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Parametrised multi-channel clock-enable divider for the display and keyboard timing paths. It replaces the fixed single power-of-two divider with CHANNELS independent channels, each with a runtime-programmable half-period, a per-channel enable, and glitch-free reprogramming. It also provides a global phase-alignment clear. Each channel outputs a 50 %-duty square wave (e.g. 7-segment multiplexing) and a one-cycle tick at every rising edge of that wave, for use as a clock enable in the `clk` domain.

## Interface
- CHANNELS, 4: number of independent divider channels (1–8).
- WIDTH, 17: width of the counter and half-period registers.
- DEFAULT_HALF, 65536: reset half-period for every channel (2^(WIDTH-1), giving a period of 131072 clk cycles).

- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  CHANNELS  per-channel run enable.
- div_wr  in  1  one-cycle write strobe for a half-period value.
- div_sel  in  max(1,$clog2(CHANNELS))  target channel of the write.
- div_data  in  WIDTH  new half-period in clk cycles; 0 is treated as 1.
- sync_clr  in  1  restarts all channels in phase.
- clk_out  out  CHANNELS  square-wave outputs, registered.
- tick  out  CHANNELS  one-cycle pulse in the first cycle that clk_out[i] is high, registered.
- pending  out  CHANNELS  a written value is held in shadow and not yet active.

## Operation
- Per-channel state: cnt[WIDTH], half[WIDTH] (active), shadow[WIDTH], pend, clk_out, tick.
- Effective half-period: eff = (half==0) ? 1 : half. Comparison is cnt == eff-1 at full WIDTH; no overflow is possible.
- **Running** (en[i]=1, no sync_clr):
  - If cnt ≠ eff-1: cnt increments.
  - At cnt == eff-1 (terminal): cnt ← 0 and clk_out toggles. tick ← 1 only if clk_out goes 0→1. If pend=1, half ← shadow and pend ← 0 at the same edge, so the new value governs the next half-period.
- **Frozen** (en[i]=0): cnt and clk_out hold and tick ← 0. A pending shadow commits immediately (half ← shadow, pend ← 0) on the next edge.
- **Write** (div_wr=1):
  - shadow[div_sel] ← div_data and pend ← 1.
  - div_sel ≥ CHANNELS: the write is ignored.
  - A write in the same cycle as that channel's terminal count or frozen commit goes to shadow with pend=1. The previous shadow commits on that edge, and the new value commits at the following boundary.
  - A later write before commit overwrites shadow; only the last value commits.
- **sync_clr=1** (takes priority over en and terminal count): on every channel, cnt ← 0, clk_out ← 0 and tick ← 0. Any pending shadow commits. A write in the same cycle lands in shadow with pend=1 and commits at the next boundary.
- **Reset** (rst=0 at an edge, including mid-operation): cnt=0, clk_out=0, tick=0, half=shadow=DEFAULT_HALF, pend=0. Reset takes priority over sync_clr and div_wr.

## Timing
- All outputs are registered. Reset values are clk_out=0, tick=0 and pending=0.
- From release of reset or sync_clr with en[i] held at 1:
  - clk_out[i] rises on the eff-th rising edge.
  - It falls on edge 2·eff.
  - The period is 2·eff cycles, with exactly 50 % duty.
- tick[i] is high for exactly one cycle per period, coincident with the first high cycle of clk_out[i].
- pending[i] rises the edge after div_wr and falls on the committing edge.
- Enable latency: deasserting en freezes the state on the next edge. Reasserting en resumes the count from the held cnt.

## Test plan
- **Default reset:** defaults, en=4'b0001, rst high after 3 low cycles → clk_out[0] rises at edge 65536, falls at 131072. tick[0] is high exactly at edge 65536 and again at 196608. Other channels stay 0.
- **Minimum divide:** write div_data=0, then div_data=1, each to channel 1 while frozen, then en[1]=1 → clk_out[1] toggles every cycle and tick[1] pulses every 2 cycles in both cases.
- **Glitch-free reprogram:** channel 2 running with half=10; write 3 at cnt=4 → pending[2]=1. The current half-period completes at 10 cycles, then pending[2]=0 and subsequent half-periods are 3 cycles. No half-period of any other length is seen.
- **Phase alignment:** channels 0–3 running with halves 5, 7, 5, 9 and staggered starts; pulse sync_clr → all clk_out=0 next edge. Channels 0 and 2 then rise together 5 edges later, and their ticks coincide every 10 cycles.
- **Freeze:** channel 3 with half=8, en[3] dropped at cnt=5 with clk_out=1 for 20 cycles → outputs constant and tick=0. After re-enable, clk_out falls after 3 more cycles.
- **Edge cases:** reset asserted mid-period with pending set → all outputs 0 and pending 0 next edge, half=DEFAULT_HALF. A write with div_sel=CHANNELS changes nothing.
